// File: rtl/calc_pkg.sv
// Shared types for the calculator datapath and the equation display.
package calc_pkg;

  localparam int CALC_W = 10;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_MUL = 3'd2,
    OP_DIV = 3'd3,
    OP_MOD = 3'd4
  } op_e;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    ITER,
    DONE
  } state_e;

endpackage

// File: rtl/calc_divider.sv
// Restoring divider: one quotient bit per step, MSB first; serves both div and mod.
module calc_divider
  import calc_pkg::*;
#(
  parameter int W = CALC_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         step,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic [W-1:0] quo_next,
  output logic [W-1:0] rem_next
);

  logic [W-1:0] quo;
  logic [W-1:0] rem;
  logic [W-1:0] dvs;
  logic [W:0]   trial;
  logic         fits;

  // Dividend bits are shifted out of the quotient register as quotient bits shift in.
  assign trial    = {rem, quo[W-1]};
  assign fits     = trial >= {1'b0, dvs};
  assign rem_next = fits ? W'(trial - {1'b0, dvs}) : trial[W-1:0];
  assign quo_next = {quo[W-2:0], fits};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      quo <= '0;
      rem <= '0;
      dvs <= '0;
    end else if (load) begin
      quo <= dividend;
      rem <= '0;
      dvs <= divisor;
    end else if (step) begin
      quo <= quo_next;
      rem <= rem_next;
    end
  end

endmodule

// File: rtl/calc_engine.sv
// Iterative add/sub/mul/div/mod stage feeding equation_display.
// Optional AUTO_RECALC_EN: recompute whenever operands change instead of on start.
module calc_engine
  import calc_pkg::*;
#(
  parameter int W = CALC_W
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [W-1:0]   num1,
  input  logic [W-1:0]   num2,
  input  logic [2:0]     op,
  output logic           busy,
  output logic           done,
  output logic [2*W-1:0] result,
  output logic           neg,
  output logic           err
);

  localparam int CW = $clog2(W);

  state_e         state, state_d;
  logic [W-1:0]   a, b;
  logic [2:0]     op_q;
  logic [CW-1:0]  cnt;
  logic [2*W-1:0] acc, acc_next;
  logic [W-1:0]   quo_next, rem_next;
  logic           go, accept, iter_op;

`ifdef AUTO_RECALC_EN
  logic first_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      first_q <= 1'b1;
    else if (accept) first_q <= 1'b0;
  end

  assign go = first_q || ({num1, num2, op} != {a, b, op_q});
`else
  assign go = start;
`endif

  assign accept  = (state == IDLE) && go;
  assign iter_op = (op == OP_MUL) || ((op == OP_DIV || op == OP_MOD) && num2 != '0);
  assign busy    = (state != IDLE);

  // Shift-add multiply, MSB of the multiplier first; cnt doubles as the bit index.
  assign acc_next = (acc << 1) + (b[cnt] ? {{W{1'b0}}, a} : '0);

  calc_divider #(.W(W)) u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (accept),
    .step     (state == ITER),
    .dividend (num1),
    .divisor  (num2),
    .quo_next (quo_next),
    .rem_next (rem_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE: if (go) state_d = iter_op ? ITER : EXEC;
      EXEC: state_d = DONE;
      ITER: if (cnt == '0) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a      <= '0;
      b      <= '0;
      op_q   <= '0;
      cnt    <= '0;
      acc    <= '0;
      result <= '0;
      neg    <= 1'b0;
      err    <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= (state == DONE);
      case (state)
        IDLE: if (go) begin
          a    <= num1;
          b    <= num2;
          op_q <= op;
          cnt  <= CW'(W - 1);
          acc  <= '0;
        end
        EXEC: begin
          neg <= 1'b0;
          err <= 1'b0;
          case (op_q)
            OP_ADD: result <= (2*W)'({1'b0, a} + {1'b0, b});
            OP_SUB: begin
              result <= (a >= b) ? (2*W)'(a - b) : (2*W)'(b - a);
              neg    <= (a < b);
            end
            default: begin
              result <= '0;
              err    <= 1'b1;
            end
          endcase
        end
        ITER: begin
          acc <= acc_next;
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            neg <= 1'b0;
            err <= 1'b0;
            if (op_q == OP_MUL)      result <= acc_next;
            else if (op_q == OP_DIV) result <= {{W{1'b0}}, quo_next};
            else                     result <= {{W{1'b0}}, rem_next};
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/calc_engine.md
Name: calc_engine

Overview:
- Arithmetic stage directly upstream of equation_display: takes two unsigned operands and a 3-bit operator code and produces the registered result the display renders after the "=".
- Add/sub complete in one cycle. Multiply (shift-add) and divide/modulo (restoring) iterate one bit per cycle so no combinational multiplier/divider sits on the 25.1 MHz pixel-clock path.
- Result is held stable between operations so the display can sample it at any pixel.

Parameters:
- W, 10, operand width in bits (matches the num1/num2 width fed to the display).

Ports:
- clk  in  1  pixel clock from PLL outglobal
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle request; sampled only in IDLE
- num1  in  W  left operand, unsigned
- num2  in  W  right operand, unsigned
- op  in  3  operator: 0 add, 1 sub, 2 mul, 3 div, 4 mod; 5-7 invalid
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse when result/flags update
- result  out  2W  magnitude of the result, zero-extended
- neg  out  1  subtraction result is negative (result holds |num1-num2|)
- err  out  1  divide/mod by zero, or invalid op

Behaviour:
- Clock and reset: one clock (clk); rst_n is asynchronous, active-low. While rst_n is low: every output is 0, state=IDLE, iteration counter=0.
- States: IDLE, EXEC, ITER, DONE.
- IDLE:
  - start=1 latches num1/num2/op into internal registers on that edge (edge k).
  - op 0/1/invalid, or op 3/4 with num2=0 -> EXEC.
  - op 2/3/4 otherwise -> ITER with counter=W-1.
  - start=0 -> stay in IDLE.
- EXEC: single-cycle compute. Registers result/neg/err at edge k+1, then -> DONE.
- ITER: one bit per cycle. Counter decrements each cycle. When the counter reaches 0, writes result at edge k+W, then -> DONE.
- DONE: done=1 for exactly one cycle, then -> IDLE.
- Latency (edge start accepted -> done high):
  - add/sub/err: 2 cycles.
  - mul/div/mod: W+1 cycles (11 at default W).
- busy: high in EXEC/ITER/DONE, low in IDLE.
- start while busy: ignored, no queuing. Operand input changes while busy have no effect.
- result/neg/err hold their last value until the next done pulse, so the display never sees intermediate values.
- Arithmetic rules:
  - add: result = num1+num2, W+1 bits significant, neg=0.
  - sub: num1>=num2 -> result=num1-num2, neg=0; else result=num2-num1, neg=1.
  - mul: full 2W-bit product, no overflow possible.
  - div: result = floor(num1/num2). mod: result = num1 mod num2. neg=0 for both.
  - err=1 cases: div/mod with num2=0, and op 5-7. In these cases result=0 and neg=0. err is cleared by the next non-error done.
- Boundaries:
  - num1=0 for any op gives a valid result.
  - num1<num2 for div -> 0; for mod -> num1.
  - Max operands 1023*1023 = 1046529 fits in 20 bits.
- Reset asserted mid-ITER: operation abandoned, all outputs 0 immediately (async). After release, the block waits in IDLE for a new start.

Optional Feature:
- AUTO_RECALC_EN defined:
  - Block ignores the start port.
  - Generates an internal start in IDLE whenever {num1,num2,op} differs from the last latched operands, and once after reset release.
  - Lets top drive constants or switches without a start pulse.
- Not defined: only the start port initiates an operation; no comparison registers are built.

Decomposition:
- Package calc_pkg:
  - op_e enum: OP_ADD=0, OP_SUB=1, OP_MUL=2, OP_DIV=3, OP_MOD=4.
  - state_e: IDLE, EXEC, ITER, DONE.
  - localparam CALC_W=10.
- equation_display shares op_e from calc_pkg.
- One sub-module, calc_divider: restoring shift/subtract datapath (quotient, remainder registers, one step per enable). Handles both div and mod. calc_engine owns the FSM, the counter and the multiply datapath.

Test Plan:
- num1=54, num2=36, op=4, start pulse -> busy for 11 cycles; done at +11; result=18, neg=0, err=0.
- num1=36, num2=54, op=1 -> done at +2; result=18, neg=1. Then 54-36 -> result=18, neg=0.
- num1=1023, num2=1023, op=2 -> result=1046529. Then op=3 -> result=1; op=0 -> result=2046.
- num1=54, num2=0, op=3 -> done at +2; err=1, result=0. Next 54/36 -> result=1, err=0. op=6 -> err=1.
- start pulsed again 4 cycles into a div -> ignored; the original result is correct and only one done pulse occurs.
- rst_n low at cycle 5 of a mul -> all outputs 0 asynchronously. After release: busy=0; a new start operates normally. With AUTO_RECALC_EN: changing num2 alone triggers recompute with no start.
